multi_func_alu_ctrl: RTL and testbench
======================================

Name: multi_func_alu_ctrl

Overview:
Sequencer and arbiter that shares one MULTI_FUNC_ALU_UNIT between two requesters (e.g. a switch-input front end and a scripted self-test).
- Round-robin grant between the two requesters.
- Latches the winner's opcode and operands, drives the ALU operand/op lines, and waits a fixed settle time.
- Captures the 8-bit ALU result and returns it with a one-cycle done pulse.
- Sits between the requesters and the ALU unit; the ALU is treated as purely combinational.

Parameters:
OP_W, 3, opcode width
DATA_W, 3, operand width
RES_W, 8, result width
SETTLE_CYCLES, 2, cycles operands are held on the ALU before capture (legal 1..15)
NUM_OPS, 6, opcodes 0..NUM_OPS-1 are legal; higher codes are rejected

Ports:
MULTI_FUNC_ALU_CTRL_clk_xi  in  1  clock
MULTI_FUNC_ALU_CTRL_rst_xi  in  1  synchronous reset, active-high
MULTI_FUNC_ALU_CTRL_req_xi  in  2  request, bit i = requester i
MULTI_FUNC_ALU_CTRL_op0_xi / op1_xi  in  OP_W  opcode of requester 0/1
MULTI_FUNC_ALU_CTRL_a0_xi / a1_xi  in  DATA_W  operand A of requester 0/1
MULTI_FUNC_ALU_CTRL_b0_xi / b1_xi  in  DATA_W  operand B of requester 0/1
MULTI_FUNC_ALU_CTRL_gnt_xo  out  2  one-hot grant
MULTI_FUNC_ALU_CTRL_done_xo  out  2  one-cycle completion pulse, bit i = requester i
MULTI_FUNC_ALU_CTRL_err_xo  out  1  illegal opcode flag, valid with done
MULTI_FUNC_ALU_CTRL_result_xo  out  RES_W  last captured result
MULTI_FUNC_ALU_CTRL_busy_xo  out  1  high whenever state is not IDLE
MULTI_FUNC_ALU_CTRL_alu_op_xo  out  OP_W  to ALU opcode input
MULTI_FUNC_ALU_CTRL_alu_a_xo  out  DATA_W  to ALU operand A
MULTI_FUNC_ALU_CTRL_alu_b_xo  out  DATA_W  to ALU operand B
MULTI_FUNC_ALU_CTRL_alu_res_xi  in  RES_W  ALU result

Behaviour:
Clocking and reset
- One clock; reset is synchronous and active-high.
- Reset, including mid-operation, forces:
  - state = IDLE
  - gnt, done, err, busy = 0
  - result = 0
  - alu_op/a/b = 0
  - priority pointer = requester 0
  - settle counter = 0
- An in-flight request is dropped on reset and produces no done pulse.

FSM states: IDLE, DRIVE, DONE.

IDLE
- If req == 0, stay in IDLE.
- Otherwise pick the winner:
  - Only one request bit set: that requester wins.
  - Both set: the requester named by the priority pointer wins.
- On the winning edge:
  - Latch winner's op/a/b into internal registers.
  - Set gnt to the winner's bit.
  - Load counter = SETTLE_CYCLES-1.
- Next state:
  - op < NUM_OPS: DRIVE.
  - op >= NUM_OPS: DONE with err=1; the ALU lines are never driven.

DRIVE
- alu_op/a/b = latched values; they are 0 in every other state.
- Counter decrements each cycle.
- When counter == 0:
  - result <= alu_res_xi.
  - Next state DONE.
- DRIVE therefore lasts exactly SETTLE_CYCLES cycles.

DONE (one cycle)
- done[winner] = 1.
- err = 1 only for an illegal-op request, else 0.
- result holds the captured value. On error it keeps its previous value.
- Priority pointer moves to the other requester.
- Next state IDLE; gnt clears on entry to IDLE.
- No arbitration in DONE, so there is exactly one idle cycle between services.

Request handshake
- Fields are sampled only on the grant edge.
- The requester must hold req until it sees gnt.
- Dropping req after grant does not cancel the service.
- Changing fields after grant has no effect.
- A requester holding req continuously is re-served after the other requester, if that one is pending.

Timing and output stability
- Latency: req sampled in IDLE at edge k gives done high in cycle k+1+SETTLE_CYCLES (legal op), or cycle k+1 (illegal op).
- result_xo is stable from the DONE cycle until the next capture.
- err_xo is 0 except in a DONE cycle.
- gnt is high exactly during DRIVE and DONE.

Width rules: no arithmetic in this block; RES_W is passed through unchanged.

Test Plan:
- Single request, legal op: req=01, op0=2, a0=5, b0=3, ALU model returns 8'h08. Require:
  - gnt=01 for 3 cycles.
  - alu_a=5 and alu_b=3 for exactly 2 cycles.
  - done=01 in cycle 3 after sampling.
  - result=8'h08, err=0.
  - alu lines back to 0 afterwards.
- Simultaneous requests with req=11 held after reset:
  - Order of service is 0, 1, 0, 1.
  - done pulses alternate 01, 10.
  - There is one IDLE cycle between services.
- Illegal opcode: req=10, op1=7. Require:
  - done=10 and err=1 one cycle after grant.
  - alu_op/a/b stay 0 throughout.
  - result unchanged from its previous value.
- Fields change after grant: change a0 from 5 to 1 in the first DRIVE cycle. Require alu_a stays 5 and the captured result reflects 5.
- Reset mid-operation: assert rst in the second DRIVE cycle. Require:
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - A fresh req=11 is then served by requester 0 first.
- SETTLE_CYCLES=1 build: done occurs 2 cycles after the request is sampled, and result is captured correctly.

Source files
------------

// File: rtl/multi_func_alu_ctrl.sv
// Purpose : round-robin sequencer sharing one combinational ALU between two requesters.
// Latency : done pulses SETTLE_CYCLES+1 cycles after the grant edge (1 cycle for an illegal opcode).
// Backpr. : requests are sampled only in IDLE; a requester holds req until it sees its gnt bit.
//
// Ports:
//   clk_xi / rst_xi          clock, synchronous active-high reset
//   req_xi[1:0]              request bits, bit i = requester i
//   op*/a*/b*_xi             opcode and operands of requester 0/1, sampled on the grant edge
//   gnt_xo[1:0]              one-hot grant, high through DRIVE and DONE
//   done_xo[1:0]             one-cycle completion pulse to the served requester
//   err_xo                   illegal-opcode flag, valid with done
//   result_xo                last captured ALU result
//   busy_xo                  high whenever the sequencer is not idle
//   alu_op/a/b_xo, alu_res_xi  ALU operand lines (zero outside DRIVE) and its result
module multi_func_alu_ctrl #(
  parameter int OP_W          = 3,
  parameter int DATA_W        = 3,
  parameter int RES_W         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_OPS       = 6
) (
  input  logic              MULTI_FUNC_ALU_CTRL_clk_xi,
  input  logic              MULTI_FUNC_ALU_CTRL_rst_xi,
  input  logic [1:0]        MULTI_FUNC_ALU_CTRL_req_xi,
  input  logic [OP_W-1:0]   MULTI_FUNC_ALU_CTRL_op0_xi,
  input  logic [OP_W-1:0]   MULTI_FUNC_ALU_CTRL_op1_xi,
  input  logic [DATA_W-1:0] MULTI_FUNC_ALU_CTRL_a0_xi,
  input  logic [DATA_W-1:0] MULTI_FUNC_ALU_CTRL_a1_xi,
  input  logic [DATA_W-1:0] MULTI_FUNC_ALU_CTRL_b0_xi,
  input  logic [DATA_W-1:0] MULTI_FUNC_ALU_CTRL_b1_xi,
  output logic [1:0]        MULTI_FUNC_ALU_CTRL_gnt_xo,
  output logic [1:0]        MULTI_FUNC_ALU_CTRL_done_xo,
  output logic              MULTI_FUNC_ALU_CTRL_err_xo,
  output logic [RES_W-1:0]  MULTI_FUNC_ALU_CTRL_result_xo,
  output logic              MULTI_FUNC_ALU_CTRL_busy_xo,
  output logic [OP_W-1:0]   MULTI_FUNC_ALU_CTRL_alu_op_xo,
  output logic [DATA_W-1:0] MULTI_FUNC_ALU_CTRL_alu_a_xo,
  output logic [DATA_W-1:0] MULTI_FUNC_ALU_CTRL_alu_b_xo,
  input  logic [RES_W-1:0]  MULTI_FUNC_ALU_CTRL_alu_res_xi
);

  // Counter is loaded with SETTLE_CYCLES-1 so DRIVE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]        gnt_q;
  logic              ptr_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [3:0]        cnt_q;
  logic [RES_W-1:0]  result_q;
  logic              err_q;

  logic              any_req;
  logic              win_sel;
  logic              sel_legal;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // Arbitration: a lone request wins outright; on a tie the priority pointer decides.
  assign any_req   = |MULTI_FUNC_ALU_CTRL_req_xi;
  assign win_sel   = (MULTI_FUNC_ALU_CTRL_req_xi == 2'b11) ? ptr_q : MULTI_FUNC_ALU_CTRL_req_xi[1];
  assign sel_op    = win_sel ? MULTI_FUNC_ALU_CTRL_op1_xi : MULTI_FUNC_ALU_CTRL_op0_xi;
  assign sel_a     = win_sel ? MULTI_FUNC_ALU_CTRL_a1_xi  : MULTI_FUNC_ALU_CTRL_a0_xi;
  assign sel_b     = win_sel ? MULTI_FUNC_ALU_CTRL_b1_xi  : MULTI_FUNC_ALU_CTRL_b0_xi;
  assign sel_legal = (int'(sel_op) < NUM_OPS);

  // State register
  always_ff @(posedge MULTI_FUNC_ALU_CTRL_clk_xi) begin
    if (MULTI_FUNC_ALU_CTRL_rst_xi) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          // Illegal opcodes skip DRIVE so the ALU lines are never exercised.
          state_nxt = sel_legal ? DRIVE : DONE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, settle counter, result capture and priority pointer
  always_ff @(posedge MULTI_FUNC_ALU_CTRL_clk_xi) begin
    if (MULTI_FUNC_ALU_CTRL_rst_xi) begin
      gnt_q    <= 2'b00;
      ptr_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= 4'd0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q <= win_sel ? 2'b10 : 2'b01;
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            cnt_q <= CNT_INIT;
            err_q <= ~sel_legal;
          end
        end
        DRIVE: begin
          if (cnt_q == 4'd0) begin
            result_q <= MULTI_FUNC_ALU_CTRL_alu_res_xi;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          // Pointer hands priority to whichever requester was not just served.
          ptr_q <= gnt_q[0];
          gnt_q <= 2'b00;
          err_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    MULTI_FUNC_ALU_CTRL_gnt_xo    = gnt_q;
    MULTI_FUNC_ALU_CTRL_busy_xo   = (state != IDLE);
    MULTI_FUNC_ALU_CTRL_done_xo   = 2'b00;
    MULTI_FUNC_ALU_CTRL_err_xo    = 1'b0;
    MULTI_FUNC_ALU_CTRL_alu_op_xo = '0;
    MULTI_FUNC_ALU_CTRL_alu_a_xo  = '0;
    MULTI_FUNC_ALU_CTRL_alu_b_xo  = '0;
    case (state)
      DRIVE: begin
        MULTI_FUNC_ALU_CTRL_alu_op_xo = op_q;
        MULTI_FUNC_ALU_CTRL_alu_a_xo  = a_q;
        MULTI_FUNC_ALU_CTRL_alu_b_xo  = b_q;
      end
      DONE: begin
        MULTI_FUNC_ALU_CTRL_done_xo = gnt_q;
        MULTI_FUNC_ALU_CTRL_err_xo  = err_q;
      end
      default: begin
      end
    endcase
  end

  assign MULTI_FUNC_ALU_CTRL_result_xo = result_q;

endmodule

// File: tb/tb_multi_func_alu_ctrl.sv
// Bench for multi_func_alu_ctrl: one instance with SETTLE_CYCLES=2 and one with
// SETTLE_CYCLES=1, each wired to a combinational ALU model.
module tb_multi_func_alu_ctrl;
  localparam int OP_W    = 3;
  localparam int DATA_W  = 3;
  localparam int RES_W   = 8;
  localparam int NUM_OPS = 6;
  localparam int S       = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        req;
  logic [OP_W-1:0]   op0, op1;
  logic [DATA_W-1:0] a0, a1, b0, b1;

  logic [1:0]        gnt, done;
  logic              err, busy;
  logic [RES_W-1:0]  result, alu_res;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b;

  logic [1:0]        gnt_1, done_1;
  logic              err_1, busy_1;
  logic [RES_W-1:0]  result_1, alu_res_1;
  logic [OP_W-1:0]   alu_op_1;
  logic [DATA_W-1:0] alu_a_1, alu_b_1;

  int checks = 0;
  int errors = 0;

  // Reference state: expected held result and expected priority pointer.
  logic [RES_W-1:0] exp_result;
  logic             ptr_m;

  function automatic logic [RES_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [RES_W-1:0] x, y;
    x = RES_W'(a);
    y = RES_W'(b);
    case (int'(op))
      0:       return x & y;
      1:       return x | y;
      2:       return x + y;
      3:       return x - y;
      4:       return x * y;
      5:       return x ^ y;
      default: return 8'hEE;
    endcase
  endfunction

  assign alu_res   = alu_fn(alu_op, alu_a, alu_b);
  assign alu_res_1 = alu_fn(alu_op_1, alu_a_1, alu_b_1);

  multi_func_alu_ctrl #(.OP_W(OP_W), .DATA_W(DATA_W), .RES_W(RES_W),
                        .SETTLE_CYCLES(S), .NUM_OPS(NUM_OPS)) dut (
    .MULTI_FUNC_ALU_CTRL_clk_xi(clk),       .MULTI_FUNC_ALU_CTRL_rst_xi(rst),
    .MULTI_FUNC_ALU_CTRL_req_xi(req),
    .MULTI_FUNC_ALU_CTRL_op0_xi(op0),       .MULTI_FUNC_ALU_CTRL_op1_xi(op1),
    .MULTI_FUNC_ALU_CTRL_a0_xi(a0),         .MULTI_FUNC_ALU_CTRL_a1_xi(a1),
    .MULTI_FUNC_ALU_CTRL_b0_xi(b0),         .MULTI_FUNC_ALU_CTRL_b1_xi(b1),
    .MULTI_FUNC_ALU_CTRL_gnt_xo(gnt),       .MULTI_FUNC_ALU_CTRL_done_xo(done),
    .MULTI_FUNC_ALU_CTRL_err_xo(err),       .MULTI_FUNC_ALU_CTRL_result_xo(result),
    .MULTI_FUNC_ALU_CTRL_busy_xo(busy),     .MULTI_FUNC_ALU_CTRL_alu_op_xo(alu_op),
    .MULTI_FUNC_ALU_CTRL_alu_a_xo(alu_a),   .MULTI_FUNC_ALU_CTRL_alu_b_xo(alu_b),
    .MULTI_FUNC_ALU_CTRL_alu_res_xi(alu_res)
  );

  multi_func_alu_ctrl #(.OP_W(OP_W), .DATA_W(DATA_W), .RES_W(RES_W),
                        .SETTLE_CYCLES(1), .NUM_OPS(NUM_OPS)) dut_s1 (
    .MULTI_FUNC_ALU_CTRL_clk_xi(clk),       .MULTI_FUNC_ALU_CTRL_rst_xi(rst),
    .MULTI_FUNC_ALU_CTRL_req_xi(req),
    .MULTI_FUNC_ALU_CTRL_op0_xi(op0),       .MULTI_FUNC_ALU_CTRL_op1_xi(op1),
    .MULTI_FUNC_ALU_CTRL_a0_xi(a0),         .MULTI_FUNC_ALU_CTRL_a1_xi(a1),
    .MULTI_FUNC_ALU_CTRL_b0_xi(b0),         .MULTI_FUNC_ALU_CTRL_b1_xi(b1),
    .MULTI_FUNC_ALU_CTRL_gnt_xo(gnt_1),     .MULTI_FUNC_ALU_CTRL_done_xo(done_1),
    .MULTI_FUNC_ALU_CTRL_err_xo(err_1),     .MULTI_FUNC_ALU_CTRL_result_xo(result_1),
    .MULTI_FUNC_ALU_CTRL_busy_xo(busy_1),   .MULTI_FUNC_ALU_CTRL_alu_op_xo(alu_op_1),
    .MULTI_FUNC_ALU_CTRL_alu_a_xo(alu_a_1), .MULTI_FUNC_ALU_CTRL_alu_b_xo(alu_b_1),
    .MULTI_FUNC_ALU_CTRL_alu_res_xi(alu_res_1)
  );

  // Inputs change right after a falling edge; outputs are read after the next falling edge.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 2'b00;
    step; step;
    checks++;
    if ({gnt, done, err, busy, result, alu_op, alu_a, alu_b} !== '0)
      begin errors++; $display("FAIL reset_outputs got %h want 0", {gnt, done, err, busy, result, alu_op, alu_a, alu_b}); end
    rst = 1'b0;
    step;
    checks++;
    if ({busy, gnt, done} !== 5'b0)
      begin errors++; $display("FAIL reset_idle got busy=%b gnt=%b done=%b want 0", busy, gnt, done); end
    ptr_m = 1'b0; exp_result = '0;
  endtask

  task automatic test_single;
    logic [12:0] got, want;
    req = 2'b01; op0 = 3'd2; a0 = 3'd5; b0 = 3'd3;
    for (int c = 1; c <= 5; c++) begin
      step;
      if (c == 1) req = 2'b00;
      got  = {gnt, done, alu_op, alu_a, alu_b};
      want = {(c <= 3) ? 2'b01 : 2'b00, (c == 3) ? 2'b01 : 2'b00,
              (c <= 2) ? 3'd2 : 3'd0, (c <= 2) ? 3'd5 : 3'd0, (c <= 2) ? 3'd3 : 3'd0};
      checks++;
      if (got !== want) begin errors++; $display("FAIL single_c%0d got %h want %h", c, got, want); end
      if (c == 3) begin
        checks++;
        if (result !== 8'h08 || err !== 1'b0)
          begin errors++; $display("FAIL single_result got %h err=%b want 08 err=0", result, err); end
      end
    end
    exp_result = 8'h08; ptr_m = 1'b1;
  endtask

  task automatic test_illegal;
    req = 2'b10; op1 = 3'd7; a1 = 3'd3; b1 = 3'd2;
    step;
    req = 2'b00;
    checks++;
    if ({gnt, done, err, busy} !== 6'b10_10_1_1)
      begin errors++; $display("FAIL illegal_done got gnt=%b done=%b err=%b busy=%b want 10 10 1 1", gnt, done, err, busy); end
    checks++;
    if ({alu_op, alu_a, alu_b} !== 9'b0 || result !== exp_result)
      begin errors++; $display("FAIL illegal_alu got alu=%h result=%h want 0 %h", {alu_op, alu_a, alu_b}, result, exp_result); end
    step;
    checks++;
    if ({gnt, done, err, busy} !== 6'b0 || result !== exp_result)
      begin errors++; $display("FAIL illegal_after got gnt=%b done=%b err=%b result=%h want 0 %h", gnt, done, err, result, exp_result); end
    ptr_m = 1'b0;
  endtask

  task automatic test_field_change;
    logic [RES_W-1:0] want;
    want = alu_fn(3'd2, 3'd5, 3'd6);
    req = 2'b01; op0 = 3'd2; a0 = 3'd5; b0 = 3'd6;
    for (int c = 1; c <= 3; c++) begin
      step;
      if (c == 1) begin req = 2'b00; a0 = 3'd1; b0 = 3'd0; op0 = 3'd0; end
      if (c <= 2) begin
        checks++;
        if (alu_a !== 3'd5 || alu_b !== 3'd6 || alu_op !== 3'd2)
          begin errors++; $display("FAIL field_change_c%0d got a=%0d b=%0d op=%0d want 5 6 2", c, alu_a, alu_b, alu_op); end
      end else begin
        checks++;
        if (done !== 2'b01 || result !== want)
          begin errors++; $display("FAIL field_change_result got done=%b result=%h want 01 %h", done, result, want); end
      end
    end
    step;
    exp_result = want; ptr_m = 1'b1;
  endtask

  task automatic test_random;
    int r, lat, seen;
    logic [OP_W-1:0] op;
    logic [DATA_W-1:0] a, b;
    logic legal;
    logic [1:0] oh;
    logic [RES_W-1:0] want;
    for (int i = 0; i < 24; i++) begin
      r  = int'($urandom_range(0, 1));
      op = OP_W'($urandom_range(0, 7));
      a  = DATA_W'($urandom);
      b  = DATA_W'($urandom);
      oh = (r == 1) ? 2'b10 : 2'b01;
      legal = (int'(op) < NUM_OPS);
      lat   = legal ? S + 1 : 1;
      want  = legal ? alu_fn(op, a, b) : exp_result;
      if (r == 1) begin op1 = op; a1 = a; b1 = b; end
      else        begin op0 = op; a0 = a; b0 = b; end
      req = oh; seen = 0;
      for (int c = 1; c <= 8 && seen == 0; c++) begin
        step;
        if (c == 1) begin
          checks++;
          if (gnt !== oh) begin errors++; $display("FAIL rand%0d_gnt got %b want %b", i, gnt, oh); end
          req = 2'b00;
          if (r == 1) begin op1 = OP_W'($urandom); a1 = DATA_W'($urandom); b1 = DATA_W'($urandom); end
          else        begin op0 = OP_W'($urandom); a0 = DATA_W'($urandom); b0 = DATA_W'($urandom); end
        end
        if (done !== 2'b00) begin
          seen = 1;
          checks++;
          if (c != lat || done !== oh || err !== ~legal || result !== want)
            begin errors++; $display("FAIL rand%0d_done got cyc=%0d done=%b err=%b res=%h want %0d %b %b %h", i, c, done, err, result, lat, oh, ~legal, want); end
          checks++;
          if ({alu_op, alu_a, alu_b} !== 9'b0)
            begin errors++; $display("FAIL rand%0d_alu_done got %h want 0", i, {alu_op, alu_a, alu_b}); end
        end else begin
          checks++;
          if (err !== 1'b0 || {alu_op, alu_a, alu_b} !== (legal ? {op, a, b} : 9'b0))
            begin errors++; $display("FAIL rand%0d_drive_c%0d got err=%b alu=%h want 0 %h", i, c, err, {alu_op, alu_a, alu_b}, legal ? {op, a, b} : 9'b0); end
        end
      end
      if (seen == 0) begin checks++; errors++; $display("FAIL rand%0d_timeout got no done want done", i); end
      exp_result = want; ptr_m = ~oh[1];
      step;
      checks++;
      if (busy !== 1'b0 || gnt !== 2'b00 || result !== exp_result)
        begin errors++; $display("FAIL rand%0d_idle got busy=%b gnt=%b res=%h want 0 00 %h", i, busy, gnt, result, exp_result); end
    end
  endtask

  task automatic test_round_robin;
    logic [RES_W-1:0] want_res [2];
    int n, last, idle_chk, gap;
    logic w;
    rst = 1'b1; req = 2'b11;
    op0 = OP_W'($urandom_range(0, NUM_OPS - 1)); a0 = DATA_W'($urandom); b0 = DATA_W'($urandom);
    op1 = OP_W'($urandom_range(0, NUM_OPS - 1)); a1 = DATA_W'($urandom); b1 = DATA_W'($urandom);
    step;
    rst = 1'b0; ptr_m = 1'b0; exp_result = '0;
    want_res[0] = alu_fn(op0, a0, b0);
    want_res[1] = alu_fn(op1, a1, b1);
    n = 0; last = 0; idle_chk = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      step;
      if (idle_chk != 0) begin
        checks++;
        if (busy !== 1'b0 || gnt !== 2'b00)
          begin errors++; $display("FAIL rr_idle%0d got busy=%b gnt=%b want 0 00", n, busy, gnt); end
        idle_chk = 0;
      end
      if (done !== 2'b00) begin
        w = ptr_m;
        gap = (n == 0) ? S + 1 : S + 2;
        checks++;
        if (done !== (w ? 2'b10 : 2'b01) || result !== want_res[w] || (c - last) != gap)
          begin errors++; $display("FAIL rr_svc%0d got done=%b res=%h gap=%0d want %b %h %0d", n, done, result, c - last, w ? 2'b10 : 2'b01, want_res[w], gap); end
        last = c; ptr_m = ~w; exp_result = want_res[w]; n++; idle_chk = 1;
      end
    end
    req = 2'b00;
    if (n < 4) begin checks++; errors++; $display("FAIL rr_timeout got %0d services want 4", n); end
    step;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_end got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [RES_W-1:0] want_res [2];
    int n;
    req = 2'b01; op0 = 3'd2; a0 = 3'd5; b0 = 3'd3;
    step;
    req = 2'b00;
    step;
    rst = 1'b1;
    step;
    checks++;
    if ({gnt, done, err, busy, result, alu_op, alu_a, alu_b} !== '0)
      begin errors++; $display("FAIL midrst_outputs got %h want 0", {gnt, done, err, busy, result, alu_op, alu_a, alu_b}); end
    rst = 1'b0; ptr_m = 1'b0; exp_result = '0;
    for (int c = 0; c < 4; c++) begin
      step;
      checks++;
      if (done !== 2'b00 || busy !== 1'b0)
        begin errors++; $display("FAIL midrst_quiet_c%0d got done=%b busy=%b want 00 0", c, done, busy); end
    end
    op0 = OP_W'($urandom_range(0, NUM_OPS - 1)); a0 = DATA_W'($urandom); b0 = DATA_W'($urandom);
    op1 = OP_W'($urandom_range(0, NUM_OPS - 1)); a1 = DATA_W'($urandom); b1 = DATA_W'($urandom);
    want_res[0] = alu_fn(op0, a0, b0);
    want_res[1] = alu_fn(op1, a1, b1);
    req = 2'b11; n = 0;
    for (int c = 1; c <= 30 && n < 2; c++) begin
      step;
      if (gnt[0] === 1'b1) req[0] = 1'b0;
      if (gnt[1] === 1'b1) req[1] = 1'b0;
      if (done !== 2'b00) begin
        checks++;
        if (done !== ((n == 0) ? 2'b01 : 2'b10) || result !== want_res[n])
          begin errors++; $display("FAIL midrst_svc%0d got done=%b res=%h want %b %h", n, done, result, (n == 0) ? 2'b01 : 2'b10, want_res[n]); end
        n++;
      end
    end
    req = 2'b00;
    if (n < 2) begin checks++; errors++; $display("FAIL midrst_timeout got %0d services want 2", n); end
    step;
    ptr_m = 1'b0; exp_result = want_res[1];
  endtask

  task automatic test_settle1;
    int r, seen;
    logic [OP_W-1:0] op;
    logic [DATA_W-1:0] a, b;
    logic [1:0] oh;
    rst = 1'b1; req = 2'b00;
    step;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r  = int'($urandom_range(0, 1));
      op = OP_W'($urandom_range(0, NUM_OPS - 1));
      a  = DATA_W'($urandom);
      b  = DATA_W'($urandom);
      oh = (r == 1) ? 2'b10 : 2'b01;
      if (r == 1) begin op1 = op; a1 = a; b1 = b; end
      else        begin op0 = op; a0 = a; b0 = b; end
      req = oh; seen = 0;
      for (int c = 1; c <= 6 && seen == 0; c++) begin
        step;
        if (c == 1) begin
          checks++;
          if (gnt_1 !== oh || {alu_op_1, alu_a_1, alu_b_1} !== {op, a, b})
            begin errors++; $display("FAIL s1_%0d_drive got gnt=%b alu=%h want %b %h", i, gnt_1, {alu_op_1, alu_a_1, alu_b_1}, oh, {op, a, b}); end
          req = 2'b00;
        end
        if (done_1 !== 2'b00) begin
          seen = 1;
          checks++;
          if (c != 2 || done_1 !== oh || err_1 !== 1'b0 || result_1 !== alu_fn(op, a, b))
            begin errors++; $display("FAIL s1_%0d_done got cyc=%0d done=%b err=%b res=%h want 2 %b 0 %h", i, c, done_1, err_1, result_1, oh, alu_fn(op, a, b)); end
        end
      end
      if (seen == 0) begin checks++; errors++; $display("FAIL s1_%0d_timeout got no done want done", i); end
      step;
      checks++;
      if (busy_1 !== 1'b0) begin errors++; $display("FAIL s1_%0d_idle got busy=%b want 0", i, busy_1); end
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00;
    op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    exp_result = '0; ptr_m = 1'b0;
    test_reset;
    test_single;
    test_illegal;
    test_field_change;
    test_random;
    test_round_robin;
    test_reset_mid;
    test_settle1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
